// File: rtl/qsn_pkg_len15.sv
// qsn_pkg_len15: shared constants, shift direction type and select-check helpers for the length-15 QSN datapath.
package qsn_pkg_len15;
  localparam int PERMUTATION_LENGTH = 15;
  localparam int QUAN_SIZE = 4;
  localparam int SHIFT_W = 4;
  localparam int MERGE_W = 14;
  localparam int MSG_W = 60;
  typedef enum logic {SHIFT_LEFT, SHIFT_RIGHT} shift_dir_e;
  // Lanes that take the left shifter result for a cyclic shift of s.
  function automatic logic [MERGE_W-1:0] merge_mask(input logic [SHIFT_W-1:0] s);
    merge_mask = '0;
    for (int i = 0; i < MERGE_W; i++)
      merge_mask[i] = (s != '0) && (i < PERMUTATION_LENGTH - int'(s));
  endfunction
  function automatic logic sel_bad(input logic [SHIFT_W-1:0] l, input logic [SHIFT_W-1:0] r,
                                   input logic [MERGE_W-1:0] m);
    sel_bad = (l == 4'd15) ||
              ((l != '0) && ({1'b0, l} + {1'b0, r} != 5'd15)) ||
              ((l == '0) && ((r != '0) || (m != merge_mask(l))));
  endfunction
endpackage

// File: rtl/qsn_barrel_shifter_len15.sv
// qsn_barrel_shifter_len15: lane-granular zero-fill shifter; LEFT moves lane i+s to lane i, RIGHT moves lane i-s to lane i.
module qsn_barrel_shifter_len15
  import qsn_pkg_len15::*;
#(
  parameter shift_dir_e DIR = SHIFT_LEFT
) (
  input  logic [MSG_W-1:0]   data,
  input  logic [SHIFT_W-1:0] shift,
  output logic [MSG_W-1:0]   result
);
  assign result = (DIR == SHIFT_LEFT) ? data >> (int'(shift) * QUAN_SIZE)
                                      : data << (int'(shift) * QUAN_SIZE);
endmodule

// File: rtl/qsn_permute_pipe_len15.sv
// qsn_permute_pipe_len15: two-stage valid/ready cyclic permuter; stage 1 barrel shifts, stage 2 merges into msg_out.
module qsn_permute_pipe_len15
  import qsn_pkg_len15::*;
#(
  parameter int TAG_W = 6
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MSG_W-1:0]   msg_in,
  input  logic [SHIFT_W-1:0] left_sel,
  input  logic [SHIFT_W-1:0] right_sel,
  input  logic [MERGE_W-1:0] merge_sel,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MSG_W-1:0]   msg_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               sel_err
);
  logic [MSG_W-1:0]   l_shift, r_shift, l_q, r_q, merged;
  logic [MERGE_W-1:0] m_q;
  logic [TAG_W-1:0]   t_q;
  logic               s1_valid, in_fire, s2_load;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  qsn_barrel_shifter_len15 #(.DIR(SHIFT_LEFT)) u_left (
    .data(msg_in), .shift(left_sel), .result(l_shift)
  );
  qsn_barrel_shifter_len15 #(.DIR(SHIFT_RIGHT)) u_right (
    .data(msg_in), .shift(right_sel), .result(r_shift)
  );
  // Lane 14 has no merge bit and always comes from the right shifter.
  always_comb begin
    merged = r_q;
    for (int i = 0; i < MERGE_W; i++)
      if (m_q[i]) merged[i*QUAN_SIZE +: QUAN_SIZE] = l_q[i*QUAN_SIZE +: QUAN_SIZE];
  end
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      l_q       <= '0;
      r_q       <= '0;
      m_q       <= '0;
      t_q       <= '0;
      msg_out   <= '0;
      tag_out   <= '0;
    end else begin
      s1_valid  <= in_fire || (s1_valid && !s2_load);
      out_valid <= s2_load || (out_valid && !out_ready);
      if (in_fire) begin
        l_q <= l_shift;
        r_q <= r_shift;
        m_q <= merge_sel;
        t_q <= tag_in;
        if (sel_bad(left_sel, right_sel, merge_sel)) sel_err <= 1'b1;
      end
      if (s2_load) begin
        msg_out <= merged;
        tag_out <= t_q;
      end
    end
  end
endmodule
